skid_register: RTL and testbench
================================

// Module: skid_register
// PURPOSE
//  Elastic 32-bit pipeline-stage register with valid/ready handshake on both sides.
//  Complements the plain enable register: the consumer applies backpressure through
//  Out_Ready instead of the producer gating an enable.
//  A 2-entry skid buffer sustains 1 word/cycle with no comb path from Out_Ready to In_Ready.
//  Sits between MIPS pipeline stages (IF/ID, ID/EX, ...) wherever a stage can stall.
// PARAMETERS
//  WIDTH        32      data width in bits
//  RESET_VALUE  32'd0   value of both data slots after reset
// PORTS
//  Clk        in   1      single clock; all state updates on posedge Clk
//  Rst_n      in   1      reset, asynchronous, active-low
//  Flush      in   1      sync clear; drops all held words
//  In_Data    in   WIDTH  upstream word
//  In_Valid   in   1      upstream word valid
//  In_Ready   out  1      block can accept a word this cycle (registered)
//  Out_Data   out  WIDTH  downstream word (registered, = main slot)
//  Out_Valid  out  1      downstream word valid (registered)
//  Out_Ready  in   1      downstream accepts Out_Data this cycle
// BEHAVIOUR
//  - Reset (Rst_n=0, async): state=EMPTY, main=skid=RESET_VALUE, Out_Valid=0, In_Ready=1.
//    Handshakes during reset are discarded.
//  - in_fire = In_Valid & In_Ready; out_fire = Out_Valid & Out_Ready.
//  - States: EMPTY (no word), ONE (main valid), FULL (main + skid valid).
//  - EMPTY: in_fire -> main<=In_Data, ONE.
//  - ONE: in_fire&out_fire -> main<=In_Data, stay ONE.
//    in_fire&!out_fire -> skid<=In_Data, FULL.
//    !in_fire&out_fire -> EMPTY.
//    Otherwise hold.
//  - FULL: In_Ready=0, so in_fire is impossible. out_fire -> main<=skid, ONE.
//    Otherwise hold.
//  - Outputs: Out_Valid = (state!=EMPTY); In_Ready = (state!=FULL).
//    Both come from state flops, not from inputs.
//  - Latency: word accepted at edge N appears on Out_Data/Out_Valid after edge N
//    (1 cycle) when EMPTY or when ONE with out_fire.
//  - Throughput: 1 word/cycle while Out_Ready=1. In_Ready drops only one cycle after
//    the first stalled cycle (skid absorbs the in-flight word).
//  - Ordering: strict FIFO; no word is duplicated or lost except on Flush.
//  - Flush: highest priority below reset. Next state EMPTY, Out_Valid=0, In_Ready=1.
//    A same-cycle in_fire word is dropped. Data slots hold their values (don't-care).
//  - Out_Data is stable while Out_Valid=1 & Out_Ready=0.
//    Upstream must hold In_Data stable while In_Valid=1 & In_Ready=0.
//  - Illegal state encoding -> EMPTY on next edge.
// STRUCTURE
//  - Shared package mips_pkg:
//    localparam WORD_WIDTH=32;
//    typedef enum logic[1:0] {SKID_EMPTY=2'b00, SKID_ONE=2'b01, SKID_FULL=2'b10} skid_state_t.
//  - Sub-module skid_slot (WIDTH-bit enabled data flop, async active-low reset),
//    instantiated twice: main and skid.
//    Control FSM and output decode live in skid_register.
// TESTING
//  1 Reset: Rst_n=0 mid-transfer in FULL -> immediately Out_Valid=0, In_Ready=1,
//    Out_Data=0. Words accepted in the reset cycle are dropped.
//  2 Streaming: Out_Ready=1, push 0x1..0x8 back-to-back -> Out_Data 0x1..0x8 on
//    consecutive cycles, 1-cycle latency, In_Ready stays 1.
//  3 Stall: push 0xA,0xB,0xC with Out_Ready=0 -> 0xA in main, 0xB in skid, In_Ready=0,
//    0xC held upstream. Raise Out_Ready -> output order 0xA,0xB,0xC, no loss.
//  4 Flush: FULL with 0x11/0x22, assert Flush with In_Valid=1 (0x33) -> next cycle
//    Out_Valid=0, In_Ready=1. 0x11, 0x22, 0x33 never appear.
//  5 Random: random In_Valid/Out_Ready 10k cycles vs scoreboard -> in-order, no
//    drop/dup. Assert Out_Data stable when Out_Valid & !Out_Ready.
//  6 Single-cycle stalls: Out_Ready toggling 1,0,1,0 with continuous In_Valid ->
//    state alternates ONE/FULL, throughput 1/2, data order preserved.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline blocks.
package mips_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/skid_slot.sv
// One data slot of the skid register: WIDTH-bit flop that loads D when En is high.
module skid_slot #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load the new word when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (En) begin
            data_d = D;
        end
    end

    // Slot storage with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign Q = data_q;

endmodule

// File: rtl/skid_register.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Out_Data is always the main slot; the skid slot absorbs the word that arrives
// in the cycle the consumer first stalls, so In_Ready is a pure state decode.
module skid_register
    import mips_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Flush,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready
);

    skid_state_t      state_q;
    skid_state_t      state_d;

    logic             main_en;
    logic             main_from_skid;
    logic             skid_en;
    logic [WIDTH-1:0] main_in;
    logic [WIDTH-1:0] skid_out;

    logic             in_fire;
    logic             out_fire;

    assign Out_Valid = (state_q != SKID_EMPTY);
    assign In_Ready  = (state_q != SKID_FULL);
    assign in_fire   = In_Valid & In_Ready;
    assign out_fire  = Out_Valid & Out_Ready;

    // Next-state and slot load control; Flush overrides any handshake.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (Flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = SKID_FULL;
                    end else if (out_fire) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = SKID_ONE;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main slot refills from the skid slot when draining a FULL buffer.
    always_comb begin
        main_in = In_Data;
        if (main_from_skid) begin
            main_in = skid_out;
        end
    end

    skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main_slot (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (main_en),
        .D     (main_in),
        .Q     (Out_Data)
    );

    skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid_slot (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (skid_en),
        .D     (In_Data),
        .Q     (skid_out)
    );

endmodule

// File: tb/tb_skid_register.sv
// Self-checking bench for skid_register against a queue-based reference model.
module tb_skid_register;

    logic        Clk;
    logic        Rst_n;
    logic        Flush;
    logic [31:0] In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;

    int checks = 0;
    int errors = 0;

    // Reference model: words currently held by the stage, oldest first (capacity 2).
    logic [31:0] mq[$];

    skid_register #(
        .WIDTH       (32),
        .RESET_VALUE (32'd0)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Flush     (Flush),
        .In_Data   (In_Data),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, advance one clock edge, update the model.
    task automatic cycle();
        bit          in_f;
        bit          out_f;
        bit          hold;
        bit          flush_at_edge;
        logic [31:0] prev_data;
        logic [31:0] in_word;
        chk("in_ready", {31'd0, In_Ready}, {31'd0, mq.size() < 2});
        chk("out_valid", {31'd0, Out_Valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) chk("out_data", Out_Data, mq[0]);
        in_f          = In_Valid && (mq.size() < 2);
        out_f         = Out_Ready && (mq.size() > 0);
        hold          = (mq.size() > 0) && !Out_Ready;
        flush_at_edge = Flush;
        prev_data     = Out_Data;
        in_word       = In_Data;
        @(posedge Clk);
        if (!Rst_n || flush_at_edge) begin
            mq.delete();
        end else begin
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(in_word);
        end
        #1;
        if (hold && !flush_at_edge && Rst_n) chk("out_stable", Out_Data, prev_data);
    endtask

    // Present word w until the model says it was accepted (bounded).
    task automatic send(input logic [31:0] w);
        bit accepted;
        In_Valid = 1'b1;
        In_Data  = w;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = (mq.size() < 2);
            cycle();
        end
        if (!accepted) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed not accepted expected accepted word %h", w);
        end
    endtask

    initial begin
        int fires;
        Rst_n     = 1'b0;
        Flush     = 1'b0;
        In_Data   = '0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        #1;
        chk("por_out_data", Out_Data, 32'd0);
        cycle();
        cycle();
        Rst_n = 1'b1;
        cycle();

        // Streaming: back-to-back words with the consumer always ready.
        Out_Ready = 1'b1;
        for (int w = 1; w <= 8; w++) send(w);
        In_Valid = 1'b0;
        cycle();
        cycle();

        // Stall: A and B captured, C held upstream, then drained in order.
        Out_Ready = 1'b0;
        send(32'hA);
        send(32'hB);
        In_Valid = 1'b1;
        In_Data  = 32'hC;
        chk("stall_main", Out_Data, 32'hA);
        chk("stall_in_ready", {31'd0, In_Ready}, 32'd0);
        cycle();
        cycle();
        Out_Ready = 1'b1;
        cycle();
        chk("drain_b", Out_Data, 32'hB);
        send(32'hC);
        In_Valid = 1'b0;
        chk("drain_c", Out_Data, 32'hC);
        cycle();
        cycle();

        // Flush while FULL, with a word offered in the flush cycle.
        Out_Ready = 1'b0;
        send(32'h11);
        send(32'h22);
        Flush    = 1'b1;
        In_Valid = 1'b1;
        In_Data  = 32'h33;
        cycle();
        Flush    = 1'b0;
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        chk("flush_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("flush_in_ready", {31'd0, In_Ready}, 32'd1);
        cycle();
        cycle();

        // Single-cycle stalls: Out_Ready 1,0,1,0 with continuous input.
        fires = 0;
        for (int i = 0; i <= 8; i++) begin
            Out_Ready = (i % 2 == 0);
            In_Valid  = 1'b1;
            if (mq.size() < 2) In_Data = 32'h100 + i;
            if (i >= 1 && Out_Valid && Out_Ready) fires++;
            cycle();
        end
        chk("half_throughput", fires, 32'd4);
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        cycle();
        cycle();

        // Async reset mid-transfer while FULL; words offered during reset are dropped.
        Out_Ready = 1'b0;
        send(32'h55);
        send(32'h66);
        In_Valid = 1'b1;
        In_Data  = 32'hDEAD;
        #2;
        Rst_n = 1'b0;
        #1;
        mq.delete();
        chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
        chk("rst_out_data", Out_Data, 32'd0);
        cycle();
        cycle();
        Rst_n    = 1'b1;
        In_Valid = 1'b0;
        cycle();
        chk("post_rst_empty", {31'd0, Out_Valid}, 32'd0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 10000; n++) begin
            Out_Ready = 1'($urandom_range(0, 1));
            Flush     = ($urandom_range(0, 63) == 0);
            if (!(In_Valid && mq.size() >= 2)) begin
                In_Valid = 1'($urandom_range(0, 1));
                In_Data  = $urandom;
            end
            cycle();
        end
        Flush     = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
